// File: rtl/local_net_iface.sv
// Network interface between a processing core and the LOCAL port of the
// mesh router at (X_COORD, Y_COORD). The injection FIFO computes the routing
// sign bits at push time. A 2-entry ejection buffer hands router traffic to
// the core. The block also keeps saturating TX/RX counters and a sticky
// out-of-range-destination flag.
//
// Handshakes: every interface (core_tx, rtr_in, rtr_out, core_rx) transfers
// on a posedge where valid and ready are both high. Once valid is raised,
// the payload is held stable until that transfer happens. No ready is
// combinationally derived from the matching valid.
module local_net_iface #(
  parameter int X_COORD    = 0,
  parameter int Y_COORD    = 0,
  parameter int DATA_WIDTH = 8,
  parameter int MESH_SIDE  = 4,
  parameter int INJ_DEPTH  = 4,
  parameter int CNT_W      = 16,
  localparam int COORD_W   = $clog2(MESH_SIDE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] core_tx_data,
  input  logic [COORD_W-1:0]    core_tx_dest_x,
  input  logic [COORD_W-1:0]    core_tx_dest_y,
  input  logic                  core_tx_valid,
  output logic                  core_tx_ready,
  output logic [DATA_WIDTH-1:0] rtr_in_data,
  output logic [COORD_W-1:0]    rtr_in_dest_x,
  output logic [COORD_W-1:0]    rtr_in_dest_y,
  output logic                  rtr_in_s_delta_x,
  output logic                  rtr_in_s_delta_y,
  output logic                  rtr_in_valid,
  input  logic                  rtr_in_ready,
  input  logic [DATA_WIDTH-1:0] rtr_out_data,
  input  logic [COORD_W-1:0]    rtr_out_dest_x,
  input  logic [COORD_W-1:0]    rtr_out_dest_y,
  input  logic                  rtr_out_s_delta_x,
  input  logic                  rtr_out_s_delta_y,
  input  logic                  rtr_out_valid,
  output logic                  rtr_out_ready,
  output logic [DATA_WIDTH-1:0] core_rx_data,
  output logic                  core_rx_valid,
  input  logic                  core_rx_ready,
  output logic [CNT_W-1:0]      tx_count,
  output logic [CNT_W-1:0]      rx_count,
  output logic                  err_dest_oob
);

  localparam int PTR_W  = $clog2(INJ_DEPTH);
  localparam int ICNT_W = $clog2(INJ_DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [COORD_W-1:0]    dx;
    logic [COORD_W-1:0]    dy;
    logic                  sdx;
    logic                  sdy;
  } inj_entry_t;

  // Injection FIFO state
  inj_entry_t            inj_mem_q [INJ_DEPTH];
  logic [PTR_W-1:0]      inj_wr_q, inj_wr_d, inj_rd_q, inj_rd_d;
  logic [ICNT_W-1:0]     inj_cnt_q, inj_cnt_d;
  // Ejection buffer state
  logic [DATA_WIDTH-1:0] ej_mem_q [2];
  logic                  ej_wr_q, ej_wr_d, ej_rd_q, ej_rd_d;
  logic [1:0]            ej_cnt_q, ej_cnt_d;
  // Counters and error flag
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic                  err_q, err_d;

  logic       inj_full, inj_empty, tx_accept, dest_oob, inj_push, inj_pop;
  logic       ej_push, ej_pop;
  inj_entry_t new_entry, head;

  // The router's header fields are meaningless at the core side.
  logic unused_rtr_fields;
  assign unused_rtr_fields = ^{rtr_out_dest_x, rtr_out_dest_y,
                               rtr_out_s_delta_x, rtr_out_s_delta_y};

  assign inj_full  = (inj_cnt_q == ICNT_W'(INJ_DEPTH));
  assign inj_empty = (inj_cnt_q == '0);
  assign dest_oob  = (int'(core_tx_dest_x) >= MESH_SIDE) ||
                     (int'(core_tx_dest_y) >= MESH_SIDE);
  // An out-of-range packet is still handshaken, then silently dropped.
  assign tx_accept = core_tx_valid && core_tx_ready;
  assign inj_push  = tx_accept && !dest_oob;
  assign inj_pop   = rtr_in_valid && rtr_in_ready;

  assign new_entry.data = core_tx_data;
  assign new_entry.dx   = core_tx_dest_x;
  assign new_entry.dy   = core_tx_dest_y;
  assign new_entry.sdx  = (int'(core_tx_dest_x) < X_COORD);
  assign new_entry.sdy  = (int'(core_tx_dest_y) < Y_COORD);

  assign head             = inj_mem_q[inj_rd_q];
  assign core_tx_ready    = !inj_full;
  assign rtr_in_valid     = !inj_empty;
  // Fields read as zero while nothing is offered, so reset shows all zeros.
  assign rtr_in_data      = rtr_in_valid ? head.data : '0;
  assign rtr_in_dest_x    = rtr_in_valid ? head.dx   : '0;
  assign rtr_in_dest_y    = rtr_in_valid ? head.dy   : '0;
  assign rtr_in_s_delta_x = rtr_in_valid && head.sdx;
  assign rtr_in_s_delta_y = rtr_in_valid && head.sdy;

  assign rtr_out_ready = !ej_cnt_q[1];
  assign core_rx_valid = (ej_cnt_q != 2'd0);
  assign core_rx_data  = core_rx_valid ? ej_mem_q[ej_rd_q] : '0;
  assign ej_push       = rtr_out_valid && rtr_out_ready;
  assign ej_pop        = core_rx_valid && core_rx_ready;

  assign tx_count     = tx_cnt_q;
  assign rx_count     = rx_cnt_q;
  assign err_dest_oob = err_q;

  // Next-state for pointers, occupancies, counters and the sticky flag.
  always_comb begin
    inj_wr_d  = inj_wr_q;
    inj_rd_d  = inj_rd_q;
    inj_cnt_d = inj_cnt_q;
    ej_wr_d   = ej_wr_q;
    ej_rd_d   = ej_rd_q;
    ej_cnt_d  = ej_cnt_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    err_d     = err_q || (tx_accept && dest_oob);
    if (inj_push) inj_wr_d = inj_wr_q + PTR_W'(1);
    if (inj_pop)  inj_rd_d = inj_rd_q + PTR_W'(1);
    case ({inj_push, inj_pop})
      2'b10:   inj_cnt_d = inj_cnt_q + ICNT_W'(1);
      2'b01:   inj_cnt_d = inj_cnt_q - ICNT_W'(1);
      default: inj_cnt_d = inj_cnt_q;
    endcase
    if (ej_push) ej_wr_d = !ej_wr_q;
    if (ej_pop)  ej_rd_d = !ej_rd_q;
    case ({ej_push, ej_pop})
      2'b10:   ej_cnt_d = ej_cnt_q + 2'd1;
      2'b01:   ej_cnt_d = ej_cnt_q - 2'd1;
      default: ej_cnt_d = ej_cnt_q;
    endcase
    if (inj_pop && (tx_cnt_q != {CNT_W{1'b1}})) tx_cnt_d = tx_cnt_q + CNT_W'(1);
    if (ej_pop  && (rx_cnt_q != {CNT_W{1'b1}})) rx_cnt_d = rx_cnt_q + CNT_W'(1);
  end

  // Control registers; synchronous reset overrides any concurrent transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_wr_q  <= '0;
      inj_rd_q  <= '0;
      inj_cnt_q <= '0;
      ej_wr_q   <= 1'b0;
      ej_rd_q   <= 1'b0;
      ej_cnt_q  <= 2'd0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      inj_wr_q  <= inj_wr_d;
      inj_rd_q  <= inj_rd_d;
      inj_cnt_q <= inj_cnt_d;
      ej_wr_q   <= ej_wr_d;
      ej_rd_q   <= ej_rd_d;
      ej_cnt_q  <= ej_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      err_q     <= err_d;
    end
  end

  // Payload storage; contents are only visible through the valid-gated outputs.
  always_ff @(posedge clk) begin
    if (!rst && inj_push) inj_mem_q[inj_wr_q] <= new_entry;
    if (!rst && ej_push)  ej_mem_q[ej_wr_q]   <= rtr_out_data;
  end

endmodule

// File: tb/tb_local_net_iface.sv
// Directed bench for local_net_iface. Instance "a" sits at (2,1) in a 4x4
// mesh. Instance "b" sits at (2,1) in a 3x3 mesh with 2-bit counters, which
// exposes the out-of-range-destination flag and counter saturation.
module tb_local_net_iface;

  localparam int DW = 8;
  localparam int CW = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance a signals
  logic [DW-1:0] core_tx_data = '0;
  logic [CW-1:0] core_tx_dest_x = '0, core_tx_dest_y = '0;
  logic          core_tx_valid = 1'b0, core_tx_ready;
  logic [DW-1:0] rtr_in_data;
  logic [CW-1:0] rtr_in_dest_x, rtr_in_dest_y;
  logic          rtr_in_s_delta_x, rtr_in_s_delta_y, rtr_in_valid;
  logic          rtr_in_ready = 1'b0;
  logic [DW-1:0] rtr_out_data = '0;
  logic          rtr_out_valid = 1'b0, rtr_out_ready;
  logic [DW-1:0] core_rx_data;
  logic          core_rx_valid, core_rx_ready = 1'b0;
  logic [15:0]   tx_count, rx_count;
  logic          err_dest_oob;

  // Instance b signals
  logic [DW-1:0] b_core_tx_data = '0;
  logic [CW-1:0] b_core_tx_dest_x = '0, b_core_tx_dest_y = '0;
  logic          b_core_tx_valid = 1'b0, b_core_tx_ready;
  logic [DW-1:0] b_rtr_in_data;
  logic [CW-1:0] b_rtr_in_dest_x, b_rtr_in_dest_y;
  logic          b_rtr_in_s_delta_x, b_rtr_in_s_delta_y, b_rtr_in_valid;
  logic          b_rtr_in_ready = 1'b1;
  logic          b_rtr_out_ready, b_core_rx_valid;
  logic [DW-1:0] b_core_rx_data;
  logic [1:0]    b_tx_count, b_rx_count;
  logic          b_err_dest_oob;

  local_net_iface #(.X_COORD(2), .Y_COORD(1), .DATA_WIDTH(DW), .MESH_SIDE(4),
                    .INJ_DEPTH(4), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst),
    .core_tx_data(core_tx_data), .core_tx_dest_x(core_tx_dest_x),
    .core_tx_dest_y(core_tx_dest_y), .core_tx_valid(core_tx_valid),
    .core_tx_ready(core_tx_ready),
    .rtr_in_data(rtr_in_data), .rtr_in_dest_x(rtr_in_dest_x),
    .rtr_in_dest_y(rtr_in_dest_y), .rtr_in_s_delta_x(rtr_in_s_delta_x),
    .rtr_in_s_delta_y(rtr_in_s_delta_y), .rtr_in_valid(rtr_in_valid),
    .rtr_in_ready(rtr_in_ready),
    .rtr_out_data(rtr_out_data), .rtr_out_dest_x(2'd2), .rtr_out_dest_y(2'd1),
    .rtr_out_s_delta_x(1'b0), .rtr_out_s_delta_y(1'b0),
    .rtr_out_valid(rtr_out_valid), .rtr_out_ready(rtr_out_ready),
    .core_rx_data(core_rx_data), .core_rx_valid(core_rx_valid),
    .core_rx_ready(core_rx_ready),
    .tx_count(tx_count), .rx_count(rx_count), .err_dest_oob(err_dest_oob)
  );

  local_net_iface #(.X_COORD(2), .Y_COORD(1), .DATA_WIDTH(DW), .MESH_SIDE(3),
                    .INJ_DEPTH(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .core_tx_data(b_core_tx_data), .core_tx_dest_x(b_core_tx_dest_x),
    .core_tx_dest_y(b_core_tx_dest_y), .core_tx_valid(b_core_tx_valid),
    .core_tx_ready(b_core_tx_ready),
    .rtr_in_data(b_rtr_in_data), .rtr_in_dest_x(b_rtr_in_dest_x),
    .rtr_in_dest_y(b_rtr_in_dest_y), .rtr_in_s_delta_x(b_rtr_in_s_delta_x),
    .rtr_in_s_delta_y(b_rtr_in_s_delta_y), .rtr_in_valid(b_rtr_in_valid),
    .rtr_in_ready(b_rtr_in_ready),
    .rtr_out_data(8'h00), .rtr_out_dest_x(2'd0), .rtr_out_dest_y(2'd0),
    .rtr_out_s_delta_x(1'b0), .rtr_out_s_delta_y(1'b0),
    .rtr_out_valid(1'b0), .rtr_out_ready(b_rtr_out_ready),
    .core_rx_data(b_core_rx_data), .core_rx_valid(b_core_rx_valid),
    .core_rx_ready(1'b1),
    .tx_count(b_tx_count), .rx_count(b_rx_count), .err_dest_oob(b_err_dest_oob)
  );

  // Scoreboard: expected packets as {data, dest_x, dest_y}
  logic [DW+2*CW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: offer one packet on core_tx of instance a.
  task automatic drive_tx(input logic [DW-1:0] d, input logic [CW-1:0] dx,
                          input logic [CW-1:0] dy);
    core_tx_data   = d;
    core_tx_dest_x = dx;
    core_tx_dest_y = dy;
    core_tx_valid  = 1'b1;
  endtask

  logic [DW-1:0] dat_v [5];
  logic [CW-1:0] dx_v  [5];
  logic [CW-1:0] dy_v  [5];
  logic [DW+2*CW-1:0] e;

  initial begin
    dat_v = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
    dx_v  = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd0};
    dy_v  = '{2'd3, 2'd1, 2'd0, 2'd1, 2'd2};

    // Reset state
    tick(); tick();
    check_eq("rst_rtr_in_valid", 32'(rtr_in_valid), 32'd0);
    check_eq("rst_core_rx_valid", 32'(core_rx_valid), 32'd0);
    check_eq("rst_rtr_in_data", 32'(rtr_in_data), 32'd0);
    check_eq("rst_tx_count", 32'(tx_count), 32'd0);
    check_eq("rst_err", 32'(b_err_dest_oob), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_tx_ready", 32'(core_tx_ready), 32'd1);
    check_eq("post_rst_rtr_out_ready", 32'(rtr_out_ready), 32'd1);

    // Single injection, latency 1, header signs
    rtr_in_ready = 1'b1;
    drive_tx(8'hA5, 2'd0, 2'd3);
    tick();
    core_tx_valid = 1'b0;
    check_eq("t1_valid", 32'(rtr_in_valid), 32'd1);
    check_eq("t1_data", 32'(rtr_in_data), 32'hA5);
    check_eq("t1_dest", 32'({rtr_in_dest_x, rtr_in_dest_y}), 32'h3);
    check_eq("t1_sdx", 32'(rtr_in_s_delta_x), 32'd1);
    check_eq("t1_sdy", 32'(rtr_in_s_delta_y), 32'd0);
    tick();
    check_eq("t1_drained", 32'(rtr_in_valid), 32'd0);
    check_eq("t1_tx_count", 32'(tx_count), 32'd1);

    // Fill with router stalled: 4 accepted, 5th refused
    rtr_in_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_tx(dat_v[i], dx_v[i], dy_v[i]);
      check_eq("fill_tx_ready", 32'(core_tx_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) exp_q.push_back({dat_v[i], dx_v[i], dy_v[i]});
      tick();
      check_eq("stall_head_data", 32'(rtr_in_data), 32'h10);
    end
    core_tx_valid = 1'b0;
    tick();
    check_eq("stall_head_hold", 32'(rtr_in_data), 32'h10);
    check_eq("stall_tx_count", 32'(tx_count), 32'd1);

    // Release: drain in order, one per cycle, with model-derived signs
    rtr_in_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("drain_valid", 32'(rtr_in_valid), 32'd1);
      check_eq("drain_data", 32'(rtr_in_data), 32'(e[DW+2*CW-1:2*CW]));
      check_eq("drain_sdx", 32'(rtr_in_s_delta_x), (32'(e[2*CW-1:CW]) < 2) ? 32'd1 : 32'd0);
      check_eq("drain_sdy", 32'(rtr_in_s_delta_y), (32'(e[CW-1:0]) < 1) ? 32'd1 : 32'd0);
      tick();
    end
    check_eq("drain_empty", 32'(rtr_in_valid), 32'd0);
    check_eq("drain_tx_count", 32'(tx_count), 32'd5);

    // Ejection: 3 back-to-back offers with core stalled
    rtr_out_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      rtr_out_data = 8'hC0 + 8'(j);
      check_eq("ej_rtr_out_ready", 32'(rtr_out_ready), (j < 2) ? 32'd1 : 32'd0);
      tick();
      if (j == 0) check_eq("ej_latency_valid", 32'(core_rx_valid), 32'd1);
    end
    check_eq("ej_full_ready", 32'(rtr_out_ready), 32'd0);
    check_eq("ej_head", 32'(core_rx_data), 32'hC0);
    core_rx_ready = 1'b1;
    tick();
    check_eq("ej_head2", 32'(core_rx_data), 32'hC1);
    check_eq("ej_ready_again", 32'(rtr_out_ready), 32'd1);
    tick();
    rtr_out_valid = 1'b0;
    check_eq("ej_head3_valid", 32'(core_rx_valid), 32'd1);
    check_eq("ej_head3", 32'(core_rx_data), 32'hC2);
    tick();
    check_eq("ej_empty", 32'(core_rx_valid), 32'd0);
    check_eq("ej_rx_count", 32'(rx_count), 32'd3);
    core_rx_ready = 1'b0;

    // Reset while two packets are queued and a push is being offered
    rtr_in_ready = 1'b0;
    drive_tx(8'h61, 2'd1, 2'd1); tick();
    drive_tx(8'h62, 2'd1, 2'd1); tick();
    check_eq("pre_rst_valid", 32'(rtr_in_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    core_tx_valid = 1'b0;
    check_eq("mid_rst_valid", 32'(rtr_in_valid), 32'd0);
    check_eq("mid_rst_tx_count", 32'(tx_count), 32'd0);
    check_eq("mid_rst_rx_count", 32'(rx_count), 32'd0);
    tick();
    check_eq("mid_rst_tx_ready", 32'(core_tx_ready), 32'd1);
    check_eq("mid_rst_still_empty", 32'(rtr_in_valid), 32'd0);

    // Instance b: out-of-range destination is accepted then dropped
    b_core_tx_data = 8'h77; b_core_tx_dest_x = 2'd3; b_core_tx_dest_y = 2'd1;
    b_core_tx_valid = 1'b1;
    check_eq("oob_tx_ready", 32'(b_core_tx_ready), 32'd1);
    tick();
    b_core_tx_valid = 1'b0;
    check_eq("oob_not_queued", 32'(b_rtr_in_valid), 32'd0);
    check_eq("oob_err", 32'(b_err_dest_oob), 32'd1);
    tick(); tick();
    check_eq("oob_tx_count", 32'(b_tx_count), 32'd0);
    check_eq("oob_err_sticky", 32'(b_err_dest_oob), 32'd1);

    // Instance b: 5 injections saturate a 2-bit counter at 3
    b_core_tx_dest_x = 2'd2; b_core_tx_dest_y = 2'd2;
    b_core_tx_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      b_core_tx_data = 8'h80 + 8'(k);
      tick();
    end
    b_core_tx_valid = 1'b0;
    tick(); tick();
    check_eq("sat_tx_count", 32'(b_tx_count), 32'd3);
    check_eq("sat_empty", 32'(b_rtr_in_valid), 32'd0);
    check_eq("sat_err_sticky", 32'(b_err_dest_oob), 32'd1);

    // Only reset clears the sticky flag
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("err_cleared", 32'(b_err_dest_oob), 32'd0);
    check_eq("b_tx_count_cleared", 32'(b_tx_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
